// File: rtl/mood_update_scheduler.sv
// mood_update_scheduler: time-multiplexes one saturating inc/dec unit over the energy, stress and pleasure counters
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   tick                one-cycle heartbeat; starts a sequence and captures inc/dec
//   inc, dec            per-channel requests (bit0 energy, bit1 stress, bit2 pleasure)
//   load                loads SET_VAL into all counters and aborts any sequence
//   energy, stress,
//   pleasure            counter values
//   busy, done          sequence in progress / one-cycle completion pulse
//   overrun             sticky: a tick arrived mid-sequence and was dropped
//   dead                energy is zero
//   overrun_cnt         saturating dropped-tick count (only with MOOD_SCHED_OVERRUN_CNT_EN)
module mood_update_scheduler #(
  parameter int N       = 7,
  parameter int SET_VAL = 64,
  parameter int DEF_E   = 96,
  parameter int DEF_S   = 0,
  parameter int DEF_P   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [2:0]   inc,
  input  logic [2:0]   dec,
  input  logic         load,
  output logic [N-1:0] energy,
  output logic [N-1:0] stress,
  output logic [N-1:0] pleasure,
  output logic         busy,
  output logic         done,
  output logic         overrun,
`ifdef MOOD_SCHED_OVERRUN_CNT_EN
  output logic [7:0]   overrun_cnt,
`endif
  output logic         dead
);
  typedef enum logic [2:0] {IDLE, UPD0, UPD1, UPD2, FIN} state_t;
  localparam logic [N-1:0] MAX = '1;
  state_t state, state_nxt;
  logic [2:0] req_inc, req_dec;
  logic [N-1:0] cur, nxt_val;
  logic [1:0] idx;
  logic accept, drop, ri, rd;
  // A tick is taken in IDLE or in the final cycle, so back-to-back sequences lose no cycle.
  assign accept = tick && !load && (state == IDLE || state == FIN);
  assign drop   = tick && !load && (state == UPD0 || state == UPD1 || state == UPD2);
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  always_comb begin
    state_nxt = load           ? IDLE :
                state == UPD0  ? UPD1 :
                state == UPD1  ? UPD2 :
                state == UPD2  ? FIN  :
                accept         ? UPD0 : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    done = state == FIN;
  end
  assign dead = energy == '0;
  always_comb begin
    idx     = state == UPD0 ? 2'd0 : state == UPD1 ? 2'd1 : 2'd2;
    cur     = state == UPD0 ? energy : state == UPD1 ? stress : pleasure;
    ri      = req_inc[idx];
    rd      = req_dec[idx];
    nxt_val = (ri && !rd && cur != MAX) ? cur + N'(1) :
              (rd && !ri && cur != '0)  ? cur - N'(1) : cur;
  end
  always_ff @(posedge clk)
    if (rst) begin
      energy   <= N'(DEF_E);
      stress   <= N'(DEF_S);
      pleasure <= N'(DEF_P);
      req_inc  <= '0;
      req_dec  <= '0;
      overrun  <= 1'b0;
    end else if (load) begin
      energy   <= N'(SET_VAL);
      stress   <= N'(SET_VAL);
      pleasure <= N'(SET_VAL);
      req_inc  <= '0;
      req_dec  <= '0;
    end else begin
      if (accept) begin
        req_inc <= inc;
        req_dec <= dec;
      end
      if (state == UPD0) energy <= nxt_val;
      if (state == UPD1) stress <= nxt_val;
      if (state == UPD2) pleasure <= nxt_val;
      if (drop) overrun <= 1'b1;
    end
`ifdef MOOD_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge clk)
    if (rst) overrun_cnt <= '0;
    else if (drop && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_mood_update_scheduler.sv
// tb_mood_update_scheduler: directed self-checking bench for mood_update_scheduler
module tb_mood_update_scheduler;
  logic clk = 0, rst = 0, tick = 0, load = 0;
  logic [2:0] inc = 0, dec = 0;
  logic [6:0] energy, stress, pleasure;
  logic busy, done, overrun, dead;
`ifdef MOOD_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif
  int checks = 0, errors = 0;
  mood_update_scheduler dut (
    .clk(clk), .rst(rst), .tick(tick), .inc(inc), .dec(dec), .load(load),
    .energy(energy), .stress(stress), .pleasure(pleasure),
    .busy(busy), .done(done), .overrun(overrun),
`ifdef MOOD_SCHED_OVERRUN_CNT_EN
    .overrun_cnt(overrun_cnt),
`endif
    .dead(dead)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_tick(input logic [2:0] i, input logic [2:0] d);
    tick = 1; inc = i; dec = d;
    step();
    tick = 0; inc = 0; dec = 0;
    repeat (4) step();
  endtask
  task automatic chk_vals(input string name, input int e, input int s, input int p);
    checks++;
    if (energy !== 7'(e) || stress !== 7'(s) || pleasure !== 7'(p)) begin
      errors++;
      $display("FAIL %s: got e=%0d s=%0d p=%0d expected e=%0d s=%0d p=%0d", name, energy, stress, pleasure, e, s, p);
    end
  endtask
  task automatic test_reset();
    rst = 1; step(); rst = 0; step();
    chk_vals("reset_vals", 96, 0, 64);
    checks++;
    if ({busy, done, overrun, dead} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got busy/done/overrun/dead=%b expected 0000", {busy, done, overrun, dead});
    end
  endtask
  task automatic test_basic();
    int busy_cycles = 0, done_cycles = 0;
    tick = 1; inc = 3'b010; dec = 3'b001;
    step();
    tick = 0; inc = 0; dec = 0;
    busy_cycles += busy; done_cycles += done;
    chk_vals("basic_t0", 96, 0, 64);
    step(); busy_cycles += busy; done_cycles += done;
    chk_vals("basic_t1", 95, 0, 64);
    step(); busy_cycles += busy; done_cycles += done;
    chk_vals("basic_t2", 95, 1, 64);
    step(); busy_cycles += busy; done_cycles += done;
    chk_vals("basic_t3", 95, 1, 64);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", done); end
    repeat (3) begin step(); busy_cycles += busy; done_cycles += done; end
    checks++;
    if (busy_cycles != 4 || done_cycles != 1) begin
      errors++; $display("FAIL basic_counts: got busy=%0d done=%0d expected busy=4 done=1", busy_cycles, done_cycles);
    end
  endtask
  task automatic test_load_tick();
    tick = 1; load = 1; inc = 3'b111;
    step();
    tick = 0; load = 0; inc = 0;
    chk_vals("load_vals", 64, 64, 64);
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL load_tick: got busy=%b overrun=%b expected 0 0", busy, overrun);
    end
  endtask
  task automatic test_saturation();
    repeat (63) run_tick(3'b001, 3'b000);
    chk_vals("sat_e_127", 127, 64, 64);
    run_tick(3'b001, 3'b000);
    chk_vals("sat_e_hold", 127, 64, 64);
    repeat (64) run_tick(3'b000, 3'b010);
    chk_vals("sat_s_0", 127, 0, 64);
    run_tick(3'b000, 3'b010);
    chk_vals("sat_s_hold", 127, 0, 64);
  endtask
  task automatic test_simultaneous();
    int done_cycles = 0;
    tick = 1; inc = 3'b111; dec = 3'b111;
    step();
    tick = 0; inc = 0; dec = 0;
    step();
    inc = 3'b111;
    repeat (4) begin step(); done_cycles += done; end
    inc = 0;
    chk_vals("simul_vals", 127, 0, 64);
    checks++;
    if (done_cycles != 1) begin errors++; $display("FAIL simul_done: got %0d pulses expected 1", done_cycles); end
  endtask
  task automatic test_overrun();
    int done_cycles = 0;
    tick = 1; dec = 3'b001;
    step();
    tick = 0;
    step();
    tick = 1;
    step();
    tick = 0; dec = 0;
    repeat (8) begin step(); done_cycles += done; end
    chk_vals("overrun_vals", 126, 0, 64);
    checks++;
    if (done_cycles != 1 || overrun !== 1'b1) begin
      errors++; $display("FAIL overrun: got done=%0d overrun=%b expected done=1 overrun=1", done_cycles, overrun);
    end
`ifdef MOOD_SCHED_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL overrun_cnt: got %0d expected 1", overrun_cnt); end
`endif
  endtask
  task automatic test_abort();
    int done_cycles = 0;
    tick = 1; inc = 3'b001; dec = 3'b110;
    step();
    tick = 0; inc = 0; dec = 0; load = 1;
    step();
    load = 0;
    chk_vals("abort_vals", 64, 64, 64);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b expected 0", busy); end
    repeat (5) begin step(); done_cycles += done; end
    chk_vals("abort_after", 64, 64, 64);
    checks++;
    if (done_cycles != 0 || overrun !== 1'b1) begin
      errors++; $display("FAIL abort_done: got done=%0d overrun=%b expected done=0 overrun=1", done_cycles, overrun);
    end
  endtask
  task automatic test_dead();
    repeat (64) run_tick(3'b000, 3'b001);
    chk_vals("dead_vals", 0, 64, 64);
    checks++;
    if (dead !== 1'b1) begin errors++; $display("FAIL dead_set: got %b expected 1", dead); end
    run_tick(3'b001, 3'b000);
    chk_vals("dead_no_freeze", 1, 64, 64);
    checks++;
    if (dead !== 1'b0) begin errors++; $display("FAIL dead_clear: got %b expected 0", dead); end
  endtask
  task automatic test_reset_mid();
    int done_cycles = 0;
    tick = 1; inc = 3'b111;
    step();
    tick = 0; inc = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    repeat (4) begin step(); done_cycles += done; end
    chk_vals("rst_mid_vals", 96, 0, 64);
    checks++;
    if (done_cycles != 0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got done=%0d busy=%b overrun=%b expected 0 0 0", done_cycles, busy, overrun);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_load_tick();
    test_saturation();
    test_simultaneous();
    test_overrun();
    test_abort();
    test_dead();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
